regfile_read_arbiter: RTL and testbench

//   Shares the single 64-bit register-file read port (32:1 read mux) among NUM_REQ requesters.

---
 rtl/regfile_arb_pkg.sv | 16 +
 rtl/regfile_read_arbiter_rr_arbiter.sv | 32 +++
 rtl/regfile_read_arbiter.sv | 86 ++++++++
 tb/tb_regfile_read_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared register-file read-port constants and types
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    function automatic logic is_xzr(input reg_addr_t addr);
        return addr == XZR_ADDR;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// rtl/regfile_read_arbiter_rr_arbiter.sv - round-robin one-hot arbiter with encoded grant index
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] idx;

    // Walk from farthest to nearest so the candidate closest to ptr is written last and wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin sharing of the register-file read port
// Optional feature: REGFILE_ARB_XZR_EN (address 31 returns zero without using the port).
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]             req_ready,
    output reg_addr_t                      rd_sel,
    input  reg_data_t                      rd_data,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output reg_data_t                      rsp_data,
    output logic                           busy
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               grant_xzr;
    reg_addr_t          grant_addr;
    reg_addr_t          sel_q;

    // Nothing is accepted while reset is held, so no request is lost into a cleared pipeline.
    assign arb_req = reset ? '0 : req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end
    end

`ifdef REGFILE_ARB_XZR_EN
    assign grant_xzr = grant_any && is_xzr(grant_addr);
`else
    assign grant_xzr = 1'b0;
`endif

    assign req_ready = grant;
    assign busy      = |req_valid;
    assign rd_sel    = (grant_any && !grant_xzr) ? grant_addr : sel_q;
    assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            sel_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= grant_any;
            if (grant_any) begin
                rr_ptr   <= ptr_next;
                rsp_id   <= grant_idx;
                rsp_data <= grant_xzr ? '0 : rd_data;
                if (!grant_xzr) begin
                    sel_q <= grant_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - scoreboard bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*5-1:0]  req_addr;
    logic [N-1:0]    req_ready;
    logic [4:0]      rd_sel;
    logic [63:0]     rd_data;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [63:0]     rsp_data;
    logic            busy;

    logic [63:0] regs [32];

    typedef struct packed {
        logic [IW-1:0] id;
        logic [63:0]   data;
    } rsp_t;

    rsp_t        sbq[$];
    int          gnt_hist[$];
    int          rsp_ihist[$];
    logic [63:0] rsp_dhist[$];

    int          total = 0;
    int          bad   = 0;
    int          m_ptr = 0;
    logic [4:0]  m_sel = '0;
    logic [N-1:0] last_gnt = '0;

    regfile_read_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_sel];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input logic [4:0] a);
`ifdef REGFILE_ARB_XZR_EN
        if (a == 5'd31) return 64'd0;
`endif
        return regs[a];
    endfunction

    function automatic logic xzr_skip(input logic [4:0] a);
`ifdef REGFILE_ARB_XZR_EN
        return a == 5'd31;
`else
        return a != a;
`endif
    endfunction

    // Reference model: first valid requester at or after the pointer, searched modulo N.
    always @(negedge clk) begin
        int           g;
        logic [4:0]   a;
        logic [N-1:0] er;
        rsp_t         e;
        if (reset) begin
            last_gnt = '0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            er = '0;
            a  = '0;
            if (g >= 0) begin
                er[g] = 1'b1;
                a = req_addr[g*5 +: 5];
                if (!xzr_skip(a)) m_sel = a;
            end
            chk("req_ready", req_ready, er);
            chk("rd_sel", rd_sel, m_sel);
            chk("busy", busy, |req_valid);
            if (g >= 0) begin
                e.id   = IW'(g);
                e.data = exp_data(a);
                sbq.push_back(e);
                gnt_hist.push_back(g);
                m_ptr = (g + 1) % N;
            end
            last_gnt = er;
        end
    end

    // Monitor: every grant expects exactly one response at the following edge.
    always @(posedge clk) begin
        rsp_t e;
        #3;
        if (!reset) begin
            if (rsp_valid) begin
                rsp_ihist.push_back(int'(rsp_id));
                rsp_dhist.push_back(rsp_data);
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                end
            end else if (sbq.size() != 0) begin
                chk("rsp_missing", rsp_valid, 1'b1);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        sbq.delete();
        m_ptr = 0;
        m_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[i*5 +: 5] = a;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = {$urandom(), $urandom()};
        regs[5]  = 64'hA5;
        regs[31] = 64'hFFFF;
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;

        // 1. reset values, then reset in the middle of a response
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, '0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, '0);
        chk("reset_rsp_data", rsp_data, '0);
        chk("reset_rd_sel", rd_sel, '0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;
        req_valid = 4'b0001;
        set_addr(0, 5'd10);
        step();
        req_valid = '0;
        chk("pre_reset_rsp_valid", rsp_valid, 1'b1);
        #1;
        reset = 1'b1;
        sbq.delete();
        m_ptr = 0;
        m_sel = '0;
        #1;
        chk("async_reset_rsp_valid", rsp_valid, 1'b0);
        step();
        reset = 1'b0;
        req_valid = 4'b0011;
        set_addr(0, 5'd5);
        set_addr(1, 5'd12);
        step();
        chk("post_reset_rsp_id", rsp_id, 0);
        chk("post_reset_rsp_data", rsp_data, 64'hA5);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();

        // 2. all requesters valid: strict rotation
        do_reset();
        gnt_hist.delete();
        for (int i = 0; i < N; i++) set_addr(i, 5'($urandom_range(0, 30)));
        req_valid = 4'b1111;
        repeat (8) step();
        req_valid = '0;
        step();
        chk("rotation_count", gnt_hist.size(), 8);
        if (gnt_hist.size() == 8)
            for (int k = 0; k < 8; k++) chk("rotation_order", gnt_hist[k], k % 4);

        // 3. requesters 1 and 3 with pointer at 2
        do_reset();
        gnt_hist.delete();
        req_valid = 4'b0010;
        set_addr(1, 5'd3);
        step();
        req_valid = 4'b1010;
        set_addr(3, 5'd17);
        step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        chk("ptr2_count", gnt_hist.size(), 3);
        if (gnt_hist.size() == 3) begin
            chk("ptr2_first", gnt_hist[1], 3);
            chk("ptr2_second", gnt_hist[2], 1);
        end

        // 4. single requester streaming 7, 8, 9
        rsp_dhist.delete();
        req_valid = 4'b0100;
        set_addr(2, 5'd7);
        step();
        set_addr(2, 5'd8);
        step();
        set_addr(2, 5'd9);
        step();
        req_valid = '0;
        step();
        chk("stream_count", rsp_dhist.size(), 3);
        if (rsp_dhist.size() == 3) begin
            chk("stream_r7", rsp_dhist[0], regs[7]);
            chk("stream_r8", rsp_dhist[1], regs[8]);
            chk("stream_r9", rsp_dhist[2], regs[9]);
        end

        // 5. address 31
        rsp_dhist.delete();
        req_valid = 4'b0001;
        set_addr(0, 5'd31);
        step();
        req_valid = '0;
        step();
        chk("xzr_count", rsp_dhist.size(), 1);
`ifdef REGFILE_ARB_XZR_EN
        if (rsp_dhist.size() == 1) chk("xzr_data", rsp_dhist[0], 64'd0);
`else
        if (rsp_dhist.size() == 1) chk("xzr_data", rsp_dhist[0], 64'hFFFF);
`endif

        // 6. request withdrawn before it wins
        do_reset();
        rsp_ihist.delete();
        req_valid = 4'b0101;
        set_addr(0, 5'd4);
        set_addr(2, 5'd6);
        step();
        req_valid = '0;
        repeat (3) step();
        chk("withdraw_rsp_count", rsp_ihist.size(), 1);
        foreach (rsp_ihist[k]) chk("withdraw_no_rsp2", rsp_ihist[k] == 2, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // random traffic obeying the hold-until-ready rule
        do_reset();
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !last_gnt[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = $urandom_range(0, 2) != 0;
                    set_addr(i, ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
                end
            end
            step();
        end
        req_valid = '0;
        repeat (2) step();
        chk("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
